// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Holds the FSM state encoding, the Booth digit select and the iteration count.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    typedef struct packed {
        logic neg;
        logic pos;
        logic dneg;
        logic dpos;
    } booth_sel_t;

    // Operands are widened by two bits, and each iteration retires two of them.
    function automatic int booth_iters(input int w);
        return (w + 2) / 2;
    endfunction

    // Window bits are {y_add, y, y_sub}; at most one select comes out high.
    function automatic booth_sel_t booth_decode(input logic [2:0] win);
        booth_sel_t sel;
        sel.neg  =  win[2] & (win[1] ^ win[0]);
        sel.pos  = ~win[2] & (win[1] ^ win[0]);
        sel.dneg =  win[2] & ~win[1] & ~win[0];
        sel.dpos = ~win[2] &  win[1] &  win[0];
        return sel;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial-product generator.
// Maps one 3-bit multiplier window onto 0, +-M or +-2M, one bit wider than M.
module booth_pp_gen
    import mul_pkg::*;
#(
    parameter int E = 34
) (
    input  logic [2:0] win_i,
    input  logic [E-1:0] mcand_i,
    output logic [E:0] pp_o
);

    booth_sel_t sel;
    logic [E:0] m1;
    logic [E:0] m2;
    logic [E:0] mag;
    logic       sel_one;
    logic       sel_two;
    logic       negate;

    assign sel     = booth_decode(win_i);
    assign sel_one = sel.pos | sel.neg;
    assign sel_two = sel.dpos | sel.dneg;
    assign negate  = sel.neg | sel.dneg;

    // 2M never overflows E+1 bits because the extended operand carries a spare sign bit.
    assign m1 = {mcand_i[E-1], mcand_i};
    assign m2 = {mcand_i, 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi <= E; gi++) begin : g_mag
            assign mag[gi] = (sel_one & m1[gi]) | (sel_two & m2[gi]);
        end
    endgenerate

    assign pp_o = negate ? (-mag) : mag;

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier for mult/multu, one Booth digit per cycle.
// The accumulator and multiplier shift right two bits together on every iteration.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_signed,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int E  = W + 2;
    localparam int N  = booth_iters(W);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    mul_state_e     state_q, state_d;
    logic [E-1:0]   mcand_q, mcand_d;
    logic [E:0]     mplr_q, mplr_d;
    logic [2*E-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    logic [E:0]     pp;
    logic [2*E+1:0] acc_wide;
    logic [2*E+1:0] pp_wide;
    logic [2*E+1:0] sum_wide;
    logic [E-1:0]   a_ext;
    logic [E-1:0]   b_ext;
    logic           last_iter;
    logic           accept;
    logic           unused_lsbs;

    booth_pp_gen #(
        .E (E)
    ) u_pp_gen (
        .win_i   (mplr_q[2:0]),
        .mcand_i (mcand_q),
        .pp_o    (pp)
    );

    assign a_ext     = is_signed ? {{2{a[W-1]}}, a} : {2'b00, a};
    assign b_ext     = is_signed ? {{2{b[W-1]}}, b} : {2'b00, b};
    assign last_iter = (cnt_q == CW'(N - 1));
    assign accept    = start && ((state_q == IDLE) || (state_q == DONE));

    // Partial product enters at the top half; after N shifts digit i sits at weight 4^i.
    assign acc_wide = {{2{acc_q[2*E-1]}}, acc_q};
    assign pp_wide  = {pp[E], pp, {E{1'b0}}};
    assign sum_wide = acc_wide + pp_wide;

    // The two bits shifted out each cycle are already final and never read again.
    assign unused_lsbs = ^sum_wide[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = start ? BUSY : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            BUSY:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_comb begin
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (accept) begin
            mcand_d = a_ext;
            mplr_d  = {b_ext, 1'b0};
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == BUSY) begin
            acc_d  = sum_wide[2*E+1:2];
            mplr_d = {{2{mplr_q[E]}}, mplr_q[E:2]};
            cnt_d  = last_iter ? '0 : cnt_q + CW'(1);
            if (last_iter) begin
                lo_d = sum_wide[W+1:2];
                hi_d = sum_wide[2*W+1:W+2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq: hand-computed products, protocol timing,
// mid-operation reset, and Booth window patterns against a 64-bit reference.
module tb_booth_mul_seq;

    localparam int W = 32;
    localparam int N = 17;

    logic          clk;
    logic          rst;
    logic          start;
    logic          is_signed;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int            total;
    int            bad;
    int            cyc;
    logic [W-1:0]  prev_hi;
    logic [W-1:0]  prev_lo;
    logic [63:0]   exp_p;
    logic [W-1:0]  pats [10];

    booth_mul_seq #(
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Raise start for exactly one cycle; returns in the first cycle after acceptance.
    task automatic launch(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        is_signed = s;
        a         = x;
        b         = y;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Walks cycles 1..N after acceptance, then checks the DONE cycle N+1.
    // inj > 0 raises start with other operands during that busy cycle.
    task automatic expect_result(input string tag, input logic [W-1:0] ehi,
                                 input logic [W-1:0] elo, input int inj);
        for (int c = 1; c <= N; c++) begin
            chk({tag, "/busy"}, {63'd0, busy}, 64'd1);
            chk({tag, "/nodone"}, {63'd0, done}, 64'd0);
            chk({tag, "/hold"}, {hi, lo}, {prev_hi, prev_lo});
            if (c == inj) begin
                start     = 1'b1;
                is_signed = ~is_signed;
                a         = 32'h1234_5678;
                b         = 32'h0BAD_F00D;
            end
            tick();
            start = 1'b0;
        end
        chk({tag, "/done"}, {63'd0, done}, 64'd1);
        chk({tag, "/idlebusy"}, {63'd0, busy}, 64'd0);
        chk({tag, "/hi"}, {32'd0, hi}, {32'd0, ehi});
        chk({tag, "/lo"}, {32'd0, lo}, {32'd0, elo});
        prev_hi = ehi;
        prev_lo = elo;
        $display("txn %s hi=%h lo=%h expect_hi=%h expect_lo=%h cyc=%0d",
                 tag, hi, lo, ehi, elo, cyc);
    endtask

    function automatic logic [63:0] ref_mul(input logic s, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = s ? {{32{x[31]}}, x} : {32'd0, x};
        ye = s ? {{32{y[31]}}, y} : {32'd0, y};
        return xe * ye;
    endfunction

    initial begin
        total     = 0;
        bad       = 0;
        cyc       = 0;
        prev_hi   = '0;
        prev_lo   = '0;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        pats[0] = 32'h0000_0000;  pats[1] = 32'hFFFF_FFFF;
        pats[2] = 32'h5555_5555;  pats[3] = 32'hAAAA_AAAA;
        pats[4] = 32'h3333_3333;  pats[5] = 32'hCCCC_CCCC;
        pats[6] = 32'h4924_9249;  pats[7] = 32'h9249_2492;
        pats[8] = 32'h6DB6_DB6D;  pats[9] = 32'hB6DB_6DB6;

        tick();
        tick();
        chk("rst/busy", {63'd0, busy}, 64'd0);
        chk("rst/done", {63'd0, done}, 64'd0);
        chk("rst/hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        tick();
        chk("idle/busy", {63'd0, busy}, 64'd0);
        chk("idle/done", {63'd0, done}, 64'd0);

        // Hand-computed products
        launch(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_result("s_m1xm1", 32'h0000_0000, 32'h0000_0001, 0);
        tick();
        chk("after_done/done", {63'd0, done}, 64'd0);
        chk("after_done/busy", {63'd0, busy}, 64'd0);
        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_result("u_maxxmax", 32'hFFFF_FFFE, 32'h0000_0001, 0);
        tick();
        launch(1'b1, 32'h8000_0000, 32'h8000_0000);
        expect_result("s_minxmin", 32'h4000_0000, 32'h0000_0000, 0);
        tick();
        launch(1'b1, 32'h8000_0000, 32'h0000_0001);
        expect_result("s_minx1", 32'hFFFF_FFFF, 32'h8000_0000, 0);
        tick();
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_result("s_minxm1", 32'h0000_0000, 32'h8000_0000, 0);
        tick();
        launch(1'b0, 32'h8000_0000, 32'h8000_0000);
        expect_result("u_2p31sq", 32'h4000_0000, 32'h0000_0000, 0);
        tick();
        launch(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        expect_result("s_maxxmax", 32'h3FFF_FFFF, 32'h0000_0001, 0);
        tick();
        launch(1'b1, 32'h0000_0003, 32'hFFFF_FFFB);
        expect_result("s_3xm5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        tick();
        launch(1'b0, 32'h0000_0003, 32'hFFFF_FFFB);
        expect_result("u_3xbig", 32'h0000_0002, 32'hFFFF_FFF1, 0);
        tick();
        launch(1'b1, 32'h1234_5678, 32'h0000_0000);
        expect_result("s_x0", 32'h0000_0000, 32'h0000_0000, 0);
        tick();

        // Start during BUSY is ignored; start held in the DONE cycle is accepted
        launch(1'b0, 32'h0000_FFFF, 32'h0000_FFFF);
        expect_result("u_ignore5", 32'h0000_0000, 32'hFFFE_0001, 5);
        launch(1'b1, 32'hFFFF_FFFE, 32'h0000_0003);
        expect_result("s_b2b", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        tick();

        // Reset in cycle 9 of an operation, restart in cycle 11
        launch(1'b1, 32'h0000_1000, 32'h0000_2000);
        for (int c = 1; c < 9; c++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst/busy", {63'd0, busy}, 64'd0);
        chk("midrst/done", {63'd0, done}, 64'd0);
        chk("midrst/hilo", {hi, lo}, 64'd0);
        prev_hi = '0;
        prev_lo = '0;
        tick();
        launch(1'b0, 32'h0000_0007, 32'h0000_0006);
        expect_result("u_afterrst", 32'h0000_0000, 32'h0000_002A, 0);
        tick();

        // Booth window patterns at every digit position, both modes
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 10; k++) begin
                a     = $urandom;
                exp_p = ref_mul(m[0], a, pats[k]);
                launch(m[0], a, pats[k]);
                expect_result($sformatf("pat_m%0d_%0d", m, k), exp_p[63:32], exp_p[31:0], 0);
            end
        end

        // Random operands, back-to-back
        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra    = $urandom;
            rb    = $urandom;
            rs    = k[0];
            exp_p = ref_mul(rs, ra, rb);
            launch(rs, ra, rb);
            expect_result($sformatf("rnd%0d", k), exp_p[63:32], exp_p[31:0], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Sequential radix-4 Booth multiplier for the MIPS-lite execute stage, serving `mult`/`multu`.

- Each cycle it recodes one overlapping 3-bit window of the multiplier into a Booth digit (0, ±1, ±2).
- It builds the matching partial product from the multiplicand, adds it into a shifting accumulator, and after a fixed number of iterations presents the full 2W-bit product as `hi`/`lo` for the HI/LO registers.

## Interface
- `W`, default 32: operand width; must be even and ≥ 4.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: request; samples `a`, `b` and `is_signed` when accepted.
- `is_signed`, input, 1: 1 selects a two's-complement multiply (`mult`); 0 selects unsigned (`multu`).
- `a`, input, W: multiplicand.
- `b`, input, W: multiplier.
- `busy`, output, 1: high while iterating.
- `done`, output, 1: one-cycle pulse when the result becomes valid.
- `hi`, output, W: product bits [2W-1:W].
- `lo`, output, W: product bits [W-1:0].

## Operation
- **Operand extension at accept.** Both operands are extended to E = W+2 bits: sign-extended if `is_signed`, zero-extended otherwise. The multiplier register is E+1 bits, with an appended 0 below the LSB.
- **Iteration count.** N = E/2, so N = 17 for W = 32.
- **Booth recode, iteration i.** The window {y_add, y, y_sub} = multiplier bits {2i+1, 2i, 2i−1}.
  - neg = y_add & (y ^ y_sub)
  - pos = ~y_add & (y ^ y_sub)
  - dneg = y_add & ~y & ~y_sub
  - dpos = ~y_add & y & y_sub
  - At most one of these is high; none high means digit 0.
- **Partial product.** Formed as 0, M, 2M, −M or −2M, sign-extended to the accumulator width (2E bits). It is weighted by 4^i, implemented as a 2-bit arithmetic right shift of the accumulator/multiplier pair per cycle.
- **Accumulation.** Arithmetic is modulo 2^(2E). The final `{hi,lo}` is the low 2W bits and is exact for both modes.
- **States:**
  - IDLE: `start` → BUSY, loading operands, clearing the accumulator and setting the iteration counter to 0.
  - BUSY: one iteration per cycle. After iteration N−1 → DONE, and `{hi,lo}` is registered.
  - DONE: `done` = 1 for this cycle only.
    - `start` → BUSY, with a fresh load.
    - No `start` → IDLE.
- **Result hold.** `hi`/`lo` hold the last result until the next DONE. They do not change during BUSY.
- **`start` while in BUSY** is ignored; there is no queueing.
- **`rst` in any state, including mid-iteration:** next state IDLE, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, accumulator and counter cleared. The in-flight result is discarded.
- **Reset values:** `busy` 0, `done` 0, `hi` 0, `lo` 0.

## Timing
- `start` sampled high in cycle t (state IDLE or DONE):
  - `busy` = 1 in cycles t+1 … t+N.
  - `done` = 1 and the new `hi`/`lo` are valid in cycle t+N+1.
- Latency is N+1 cycles (18 for W = 32) and is independent of operand values; there is no early termination.
- Back-to-back throughput: one result per N+1 cycles, because `start` asserted during the DONE cycle is accepted.
- `busy` and `done` are never high together.

## Structure
- Shared package `mul_pkg`:
  - state enum (IDLE, BUSY, DONE);
  - Booth select struct {neg, pos, dneg, dpos};
  - function `booth_iters(W)` = (W+2)/2.
- Sub-module `booth_pp_gen`, purely combinational:
  - inputs: 3-bit window, E-bit multiplicand;
  - output: (E+1)-bit signed partial product.
- The top level contains the FSM, the iteration counter (width ⌈log2 N⌉), the accumulator and the shift logic.

## Test plan
- **Signed −1 × −1:** `is_signed`=1, `a`=`b`=0xFFFFFFFF, `start` in cycle 0 → `done` in cycle 18 with `hi`=0x00000000, `lo`=0x00000001. `busy` high in cycles 1–17.
- **Unsigned max × max:** `is_signed`=0, `a`=`b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **Signed corner cases:**
  - 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
  - 0x80000000 × 0x00000001 → `hi`=0xFFFFFFFF, `lo`=0x80000000.
- **Protocol:**
  - `start` re-asserted in cycle 5 with different operands → ignored; the first result is unchanged in cycle 18.
  - `start` held high in cycle 18 → second `done` in cycle 36.
- **Reset mid-operation:** `rst` asserted in cycle 9 → cycle 10 shows `busy`=0, `hi`=`lo`=0, and no `done` at cycle 18. A new `start` in cycle 11 gives `done` in cycle 29.
- **Random sweep:** 10k random operands in both modes against a 64-bit reference product, including all Booth window patterns 000–111 at every digit position.
